tone_gen: RTL and testbench

- Downstream audio stage of the countdown/beep path. Consumes the half-period divider value from `sound` (`sonido`), the beep gate from `tiempos` (`clk_1hz`) and the continuous-tone flag from `sound_continuado` (`cont`).
- Produces a glitch-free square wave for the buzzer pin.
- Period changes and gate changes take effect only on full-period boundaries, so the speaker never sees a runt pulse.

---
 rtl/tone_pkg.sv | 8 +
 rtl/tone_gen_if.sv | 25 ++
 rtl/tone_div_counter.sv | 27 ++
 rtl/tone_gen.sv | 91 +++++++++
 tb/tb_tone_gen.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the buzzer tone generator.
// Optional mute input is enabled with the TONE_MUTE_EN macro.
package tone_pkg;
  localparam int CNT_W_DEFAULT = 52;
  localparam int SILENCE       = 0;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} tone_state_e;
endpackage

// File: rtl/tone_gen_if.sv
// Tone generator bus: divider value, gating inputs and buzzer outputs.
// The mute input exists only when TONE_MUTE_EN is defined.
interface tone_gen_if #(parameter int CNT_W = tone_pkg::CNT_W_DEFAULT);
  logic [CNT_W-1:0] half_period;
  logic             gate;
  logic             continuo;
`ifdef TONE_MUTE_EN
  logic             mute;
`endif
  logic             audio_out;
  logic             busy;
  logic             tone_start;

`ifdef TONE_MUTE_EN
  modport master (output half_period, gate, continuo, mute,
                  input  audio_out, busy, tone_start);
  modport slave  (input  half_period, gate, continuo, mute,
                  output audio_out, busy, tone_start);
`else
  modport master (output half_period, gate, continuo,
                  input  audio_out, busy, tone_start);
  modport slave  (input  half_period, gate, continuo,
                  output audio_out, busy, tone_start);
`endif
endinterface

// File: rtl/tone_div_counter.sv
// Loadable down-counter that measures one half wave; holds at zero when idle.
module tone_div_counter
  import tone_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (cnt_q != '0)       cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/tone_gen.sv
// Glitch-free square-wave generator for the buzzer; period and gate changes
// only land on full-period boundaries. Mute input under TONE_MUTE_EN.
module tone_gen
  import tone_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  tone_gen_if.slave   bus
);
  tone_state_e      state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             audio_out_q, audio_out_d;
  logic             busy_q, busy_d;
  logic             tone_start_q, tone_start_d;
  logic             run;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  always_comb begin
    run = (bus.gate | bus.continuo) & (bus.half_period != CNT_W'(SILENCE));
`ifdef TONE_MUTE_EN
    run = run & ~bus.mute;
`endif
  end

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    load         = 1'b0;
    load_val     = per_q - CNT_W'(1);
    tone_start_d = 1'b0;
    case (state_q)
      IDLE: if (run) begin
        per_d        = bus.half_period;
        load         = 1'b1;
        load_val     = bus.half_period - CNT_W'(1);
        state_d      = HIGH;
        tone_start_d = 1'b1;
      end
      HIGH: if (zero) begin
        load    = 1'b1;
        state_d = LOW;
      end
      LOW: if (zero) begin
        // New period is only accepted here, so a half wave is never cut short.
        if (run) begin
          per_d    = bus.half_period;
          load     = 1'b1;
          load_val = bus.half_period - CNT_W'(1);
          state_d  = HIGH;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    audio_out_d = (state_d == HIGH);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      per_q        <= '0;
      audio_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      tone_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      audio_out_q  <= audio_out_d;
      busy_q       <= busy_d;
      tone_start_q <= tone_start_d;
    end
  end

  tone_div_counter #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign bus.audio_out  = audio_out_q;
  assign bus.busy       = busy_q;
  assign bus.tone_start = tone_start_q;
endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: period-position reference model checked every
// cycle, plus hand-computed waveform expectations.
module tb_tone_gen;
  localparam int W = 52;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  tone_gen_if #(.CNT_W(W)) ifc ();

  tone_gen #(.CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an active tone is a sequence of whole periods of 2*P cycles;
  // position m_pos within the period decides the level.
  bit     m_act = 0, m_start = 0, m_valid = 0;
  longint m_p = 0, m_pos = 0;

  always @(posedge clk) begin
    bit run;
    run = (ifc.gate || ifc.continuo) && (ifc.half_period != 0);
`ifdef TONE_MUTE_EN
    run = run && !ifc.mute;
`endif
    m_start = 0;
    if (reset) begin
      m_act = 0; m_pos = 0; m_p = 0;
    end else if (!m_act) begin
      if (run) begin
        m_act = 1; m_p = longint'(ifc.half_period); m_pos = 0; m_start = 1;
      end
    end else begin
      m_pos++;
      if (m_pos == 2 * m_p) begin
        if (run) begin m_p = longint'(ifc.half_period); m_pos = 0; end
        else m_act = 0;
      end
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_audio", longint'(ifc.audio_out), longint'(m_act && (m_pos < m_p)));
      chk("model_busy",  longint'(ifc.busy),      longint'(m_act));
      chk("model_start", longint'(ifc.tone_start), longint'(m_start));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (ifc.busy && n < maxc) begin step(1); n++; end
    chk("idle_timeout", longint'(ifc.busy), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    logic [8:0]  pat9;
    int highs, starts;

    ifc.half_period = 52'd4;
    ifc.gate        = 1'b1;
    ifc.continuo    = 1'b0;
`ifdef TONE_MUTE_EN
    ifc.mute        = 1'b0;
`endif
    reset = 1'b1;

    // Reset held 3 cycles with a tone requested: outputs stay quiet.
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_audio", longint'(ifc.audio_out), 0);
      chk("rst_busy",  longint'(ifc.busy), 0);
    end
    reset = 1'b0;
    pat = 16'hF0F0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("wave4_audio", longint'(ifc.audio_out), longint'(pat[15-i]));
      chk("wave4_start", longint'(ifc.tone_start), (i == 0) ? 1 : 0);
    end

    // Reset mid-wave: output drops on the next cycle.
    step(2);
    reset = 1'b1; ifc.gate = 1'b0;
    step(1);
    chk("midrst_audio", longint'(ifc.audio_out), 0);
    chk("midrst_busy",  longint'(ifc.busy), 0);
    reset = 1'b0;
    step(2);

    // Gate drops in the 2nd HIGH cycle: 3 high + 3 low still complete.
    ifc.half_period = 52'd3; ifc.gate = 1'b1;
    step(1);
    ifc.gate = 1'b0;
    step(1);
    chk("gdrop_h2", longint'(ifc.audio_out), 1);
    step(1); chk("gdrop_h3", longint'(ifc.audio_out), 1);
    step(1); chk("gdrop_l1", longint'(ifc.audio_out), 0);
    step(2); chk("gdrop_l3_busy", longint'(ifc.busy), 1);
    step(1); chk("gdrop_idle", longint'(ifc.busy), 0);
    step(6); chk("gdrop_quiet", longint'(ifc.audio_out), 0);

    // Period change 4->2 in the 2nd LOW cycle takes effect next period.
    ifc.half_period = 52'd4; ifc.gate = 1'b1;
    step(6);                          // now in LOW cycle 2
    chk("pchg_l2", longint'(ifc.audio_out), 0);
    ifc.half_period = 52'd2;
    pat9 = 9'b000110011;
    for (int i = 0; i < 9; i++) begin
      chk("pchg_audio", longint'(ifc.audio_out), longint'(pat9[8-i]));
      step(1);
    end
    ifc.gate = 1'b0;
    wait_idle(20);

    // Zero half period means silence even with gate high.
    ifc.half_period = 52'd0; ifc.gate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("silence_busy", longint'(ifc.busy), 0);
    end
    // Half period 1 toggles every cycle.
    ifc.half_period = 52'd1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("hp1_audio", longint'(ifc.audio_out), (i % 2 == 0) ? 1 : 0);
    end
    ifc.gate = 1'b0;
    wait_idle(10);

`ifdef TONE_MUTE_EN
    // Mute mid-HIGH lets the 5/5 period finish, then unmute restarts.
    ifc.half_period = 52'd5; ifc.gate = 1'b1;
    step(2);
    ifc.mute = 1'b1;
    step(3); chk("mute_h5", longint'(ifc.audio_out), 1);
    step(1); chk("mute_l1", longint'(ifc.audio_out), 0);
    step(4); chk("mute_l5_busy", longint'(ifc.busy), 1);
    step(1); chk("mute_idle", longint'(ifc.busy), 0);
    step(2);
    ifc.mute = 1'b0;
    step(1);
    chk("unmute_start", longint'(ifc.tone_start), 1);
    chk("unmute_audio", longint'(ifc.audio_out), 1);
    ifc.gate = 1'b0;
    wait_idle(20);
`endif

    // Continuous tone: 32000 high / 32000 low, no restart pulse at rollover.
    ifc.gate = 1'b0; ifc.continuo = 1'b1; ifc.half_period = 52'd32000;
    highs = 0; starts = 0;
    for (int i = 0; i < 64010; i++) begin
      step(1);
      if (i < 64000 && ifc.audio_out) highs++;
      if (ifc.tone_start) starts++;
    end
    chk("cont_high_cycles", highs, 32000);
    chk("cont_start_pulses", starts, 1);
    chk("cont_rollover_high", longint'(ifc.audio_out), 1);
    reset = 1'b1; ifc.continuo = 1'b0;
    step(1);
    chk("cont_rst_audio", longint'(ifc.audio_out), 0);
    reset = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
